// File: rtl/timer_ctrl_if.sv
// timer_ctrl_if -- link between the countdown controller and its BCD datapath.
//   cnt_zero : datapath -> controller, all four BCD digits are zero
//   cnt_load : controller -> datapath, copy preset while high
//   preset   : controller -> datapath, BCD {min1,min0,sec1,sec0}
//   cnt_dec  : controller -> datapath, one-cycle pulse, decrement mm:ss by 1 s
// master = controller side, slave = datapath side.
interface timer_ctrl_if;
   logic        cnt_zero;
   logic        cnt_load;
   logic [15:0] preset;
   logic        cnt_dec;

   modport master (input cnt_zero, output cnt_load, output preset, output cnt_dec);
   modport slave  (output cnt_zero, input cnt_load, input preset, input cnt_dec);
endinterface

// File: rtl/timer_ctrl.sv
// timer_ctrl -- countdown timer control FSM (IDLE/RUN/PAUSE/DONE).
//   clk       : sole clock, rising edge
//   rst_n     : synchronous active-low reset
//   start     : level button; each rising edge = start/pause/acknowledge
//   clr       : level; high aborts to IDLE
//   time_ctrl : preset select 00=00:30 01=01:00 10=05:00 11=10:00
//   dp        : datapath link (cnt_zero in; cnt_load, preset, cnt_dec out)
//   state     : IDLE=0 RUN=1 PAUSE=2 DONE=3
//   running   : state==RUN
//   done      : state==DONE
//   led       : alarm display, blinks FFFF/0000 once per tick in DONE
module timer_ctrl #(
   parameter int unsigned TICK_DIV = 50_000_000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                clr,
   input  logic [1:0]          time_ctrl,
   timer_ctrl_if.master        dp,
   output logic [1:0]          state,
   output logic                running,
   output logic                done,
   output logic [15:0]         led
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [26:0] DIV_LAST = 27'(TICK_DIV - 1);

   state_t      state_q;
   state_t      state_d;
   logic        start_q;
   logic        start_rise;
   logic [26:0] div_q;
   logic [26:0] div_inc;
   logic        div_wrap;
   logic [15:0] led_q;
   logic [15:0] preset_q;
   logic [15:0] preset_dec;

   assign start_rise = start & ~start_q;
   assign div_wrap   = (div_q == DIV_LAST);
   assign div_inc    = div_wrap ? '0 : div_q + 27'd1;

   always_comb begin
      preset_dec = 16'h0030;
      case (time_ctrl)
         2'b00:   preset_dec = 16'h0030;
         2'b01:   preset_dec = 16'h0100;
         2'b10:   preset_dec = 16'h0500;
         default: preset_dec = 16'h1000;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; priority clr > cnt_zero > start_rise
   always_comb begin
      state_d = state_q;
      if (clr) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (start_rise) state_d = S_RUN;
            S_RUN: begin
               if (dp.cnt_zero)     state_d = S_DONE;
               else if (start_rise) state_d = S_PAUSE;
            end
            S_PAUSE: if (start_rise) state_d = S_RUN;
            S_DONE:  if (start_rise) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Tick divider, alarm display, preset latch and start edge detector
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         start_q  <= 1'b0;
         div_q    <= '0;
         led_q    <= '0;
         preset_q <= 16'h0030;
      end else begin
         start_q <= start;
         if (state_q == S_IDLE) preset_q <= preset_dec;
         if (clr) begin
            div_q <= '0;
            led_q <= '0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  div_q <= '0;
                  led_q <= '0;
               end
               S_RUN: begin
                  if (dp.cnt_zero) begin
                     div_q <= '0;
                     led_q <= '1;
                  end else begin
                     // pausing freezes div so the resume keeps the partial tick
                     if (!start_rise) div_q <= div_inc;
                     led_q <= '0;
                  end
               end
               S_PAUSE: led_q <= '0;
               S_DONE: begin
                  if (start_rise) begin
                     div_q <= '0;
                     led_q <= '0;
                  end else begin
                     div_q <= div_inc;
                     if (div_wrap) led_q <= ~led_q;
                  end
               end
               default: begin
                  div_q <= '0;
                  led_q <= '0;
               end
            endcase
         end
      end
   end

   // Outputs
   always_comb begin
      state       = state_q;
      running     = (state_q == S_RUN);
      done        = (state_q == S_DONE);
      led         = led_q;
      dp.preset   = preset_q;
      dp.cnt_load = (state_q == S_IDLE);
      dp.cnt_dec  = (state_q == S_RUN) & div_wrap & ~dp.cnt_zero & ~clr & ~start_rise;
   end

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl -- directed, table-driven bench for timer_ctrl with TICK_DIV=4.
// Inputs change on the falling edge; outputs are compared 1 ns later.
module tb_timer_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        clr = 1'b0;
   logic [1:0]  time_ctrl = 2'b00;
   logic [1:0]  state;
   logic        running;
   logic        done;
   logic [15:0] led;

   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   timer_ctrl_if bus ();

   timer_ctrl #(.TICK_DIV(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .clr       (clr),
      .time_ctrl (time_ctrl),
      .dp        (bus.master),
      .state     (state),
      .running   (running),
      .done      (done),
      .led       (led)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        st;
      logic        cl;
      logic [1:0]  tc;
      logic        cz;
      logic        chk;
      logic [1:0]  e_state;
      logic        e_dec;
      logic [15:0] e_led;
      logic [15:0] e_pre;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, s, c, input logic [1:0] t, input logic z,
                               input logic k, input logic [1:0] es, input logic ed,
                               input logic [15:0] el, input logic [15:0] ep);
      vec_t v;
      v.rst = r; v.st = s; v.cl = c; v.tc = t; v.cz = z; v.chk = k;
      v.e_state = es; v.e_dec = ed; v.e_led = el; v.e_pre = ep;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(input logic r, s, c, input logic [1:0] t, input logic z);
      @(negedge clk);
      rst_n = r; start = s; clr = c; time_ctrl = t; bus.cnt_zero = z;
      #1;
   endtask

   task automatic chk_outs(input string tag, input logic [1:0] es, input logic ed,
                           input logic [15:0] el, input logic [15:0] ep);
      chk({tag, ".state"},    16'(state),        16'(es));
      chk({tag, ".cnt_load"}, 16'(bus.cnt_load), 16'(es == 2'd0));
      chk({tag, ".running"},  16'(running),      16'(es == 2'd1));
      chk({tag, ".done"},     16'(done),         16'(es == 2'd3));
      chk({tag, ".cnt_dec"},  16'(bus.cnt_dec),  16'(ed));
      chk({tag, ".led"},      led,               el);
      chk({tag, ".preset"},   bus.preset,        ep);
   endtask

   initial begin
      bus.cnt_zero = 1'b0;

      // reset, preset select, run with periodic decrements, pause and resume
      vecs.push_back(mk(0,0,0,2'b00,0, 0, 0,0,16'h0000,16'h0030));
      vecs.push_back(mk(0,0,0,2'b00,0, 1, 0,0,16'h0000,16'h0030));
      vecs.push_back(mk(1,0,0,2'b01,0, 1, 0,0,16'h0000,16'h0030));
      vecs.push_back(mk(1,0,0,2'b01,0, 1, 0,0,16'h0000,16'h0100));
      vecs.push_back(mk(1,1,0,2'b01,0, 1, 0,0,16'h0000,16'h0100));
      vecs.push_back(mk(1,1,0,2'b01,0, 1, 1,0,16'h0000,16'h0100));
      vecs.push_back(mk(1,0,0,2'b01,0, 1, 1,0,16'h0000,16'h0100));
      vecs.push_back(mk(1,0,0,2'b01,0, 1, 1,0,16'h0000,16'h0100));
      vecs.push_back(mk(1,0,0,2'b01,0, 1, 1,1,16'h0000,16'h0100));
      vecs.push_back(mk(1,0,0,2'b01,0, 1, 1,0,16'h0000,16'h0100));
      vecs.push_back(mk(1,0,0,2'b01,0, 1, 1,0,16'h0000,16'h0100));
      vecs.push_back(mk(1,0,0,2'b01,0, 1, 1,0,16'h0000,16'h0100));
      vecs.push_back(mk(1,0,0,2'b01,0, 1, 1,1,16'h0000,16'h0100));
      vecs.push_back(mk(1,0,0,2'b01,0, 1, 1,0,16'h0000,16'h0100));
      vecs.push_back(mk(1,0,0,2'b01,0, 1, 1,0,16'h0000,16'h0100));
      vecs.push_back(mk(1,1,0,2'b01,0, 1, 1,0,16'h0000,16'h0100));
      vecs.push_back(mk(1,1,0,2'b11,0, 1, 2,0,16'h0000,16'h0100));
      for (int i = 0; i < 9; i++)
         vecs.push_back(mk(1,0,0,2'b11,0, 1, 2,0,16'h0000,16'h0100));
      vecs.push_back(mk(1,1,0,2'b11,0, 1, 2,0,16'h0000,16'h0100));
      vecs.push_back(mk(1,1,0,2'b11,0, 1, 1,0,16'h0000,16'h0100));
      vecs.push_back(mk(1,0,0,2'b11,0, 1, 1,1,16'h0000,16'h0100));

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].st, vecs[i].cl, vecs[i].tc, vecs[i].cz);
         if (vecs[i].chk)
            chk_outs($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_dec,
                     vecs[i].e_led, vecs[i].e_pre);
      end

      // cnt_zero on the wrap cycle beats cnt_dec; DONE blink and acknowledge
      step(1,0,0,2'b11,0); chk_outs("zero_d0", 1, 0, 16'h0000, 16'h0100);
      step(1,0,0,2'b11,0); chk_outs("zero_d1", 1, 0, 16'h0000, 16'h0100);
      step(1,0,0,2'b11,0); chk_outs("zero_d2", 1, 0, 16'h0000, 16'h0100);
      step(1,0,0,2'b11,1); chk_outs("zero_d3", 1, 0, 16'h0000, 16'h0100);
      for (int i = 0; i < 9; i++) begin
         step(1, (i == 8), 0, 2'b11, 0);
         chk_outs($sformatf("blink%0d", i), 3, 0,
                  (i < 4 || i == 8) ? 16'hFFFF : 16'h0000, 16'h0100);
      end
      step(1,1,0,2'b10,0); chk_outs("ack_idle", 0, 0, 16'h0000, 16'h0100);
      step(1,0,0,2'b10,0); chk_outs("pre_0500", 0, 0, 16'h0000, 16'h0500);

      // clr together with start rise on the wrap cycle
      step(1,1,0,2'b10,0); chk_outs("b_go",   0, 0, 16'h0000, 16'h0500);
      step(1,1,0,2'b10,0); chk_outs("b_r0",   1, 0, 16'h0000, 16'h0500);
      step(1,0,0,2'b10,0); chk_outs("b_r1",   1, 0, 16'h0000, 16'h0500);
      step(1,0,0,2'b10,0); chk_outs("b_r2",   1, 0, 16'h0000, 16'h0500);
      step(1,1,1,2'b10,0); chk_outs("b_clr",  1, 0, 16'h0000, 16'h0500);
      step(1,0,0,2'b10,0); chk_outs("b_idle", 0, 0, 16'h0000, 16'h0500);
      step(1,1,0,2'b10,0); chk_outs("b_go2",  0, 0, 16'h0000, 16'h0500);
      for (int i = 0; i < 4; i++) begin
         step(1,0,0,2'b10,0);
         chk_outs($sformatf("b_div0_%0d", i), 1, (i == 3), 16'h0000, 16'h0500);
      end

      // reset during DONE with start, clr and cnt_zero all high
      step(1,0,0,2'b10,1); chk_outs("c_zero", 1, 0, 16'h0000, 16'h0500);
      step(1,0,0,2'b10,0); chk_outs("c_done", 3, 0, 16'hFFFF, 16'h0500);
      step(0,1,1,2'b10,1); chk_outs("c_rst0", 3, 0, 16'hFFFF, 16'h0500);
      step(0,1,1,2'b10,1); chk_outs("c_rst1", 0, 0, 16'h0000, 16'h0030);
      step(1,1,0,2'b10,0); chk_outs("c_rel",  0, 0, 16'h0000, 16'h0030);
      step(1,1,0,2'b10,0); chk_outs("c_run",  1, 0, 16'h0000, 16'h0500);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
